hps_avalon_responder: RTL and testbench
=======================================

Name: hps_avalon_responder

Overview:
- Fabric-side responder for the HPS Avalon initiator: accepts the HPS read/write requests (address, byte enables, data) and returns acknowledge and read data.
- Routes the lower half of the address space to a word-addressed memory port with fixed read latency, and the upper half to a small CSR block.
- The CSR block provides CPU run/step control, PC readback, a scratch register and an ID word.
- Sits in the top level between the HPS and the sc_computer memory/control.

Parameters:
- MEM_AW, 14, memory word-address width (byte address bits [MEM_AW+1:2]).
- MEM_LAT, 2, memory read latency in cycles from mem_re to valid mem_rdata (1..7).
- RUN_AT_RESET, 1, reset value of cpu_run.
- ID_VALUE, 32'h4D495053, constant returned by the ID CSR.

Ports:
- clock  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- avalon_address  in  24  byte address from HPS.
- avalon_byte_enable  in  4  byte-lane enables.
- avalon_read  in  1  read request, held until acknowledge.
- avalon_write  in  1  write request, held until acknowledge.
- avalon_write_data  in  32  write data.
- avalon_acknowledge  out  1  one-cycle completion pulse.
- avalon_read_data  out  32  read data, valid when avalon_acknowledge=1.
- mem_addr  out  MEM_AW  memory word address.
- mem_re  out  1  memory read strobe, 1 cycle.
- mem_we  out  1  memory write strobe, 1 cycle.
- mem_be  out  4  memory byte enables.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, MEM_LAT cycles after mem_re.
- pc  in  32  CPU program counter, for readback.
- cpu_run  out  1  CPU run enable, ANDed into the CPU resetn/clock-enable.
- cpu_step  out  1  single-cycle step pulse.

Behaviour:
- Reset values: all outputs 0 except cpu_run=RUN_AT_RESET; scratch=0; FSM=IDLE.
- Async reset mid-transaction: the transaction is abandoned with no acknowledge and no pending strobe.
- Address decode:
  - address[23]=0: memory region, mem_addr=address[MEM_AW+1:2]; bits above MEM_AW+1 ignored (aliasing).
  - address[23]=1: CSR region, offset address[3:2]; address[22:4] ignored.
- CSR map:
  - 0 CTRL: bit0 run (R/W), bit1 step (write-1 pulses cpu_step, reads 0). Written only when byte_enable[0]=1.
  - 1 STATUS: read-only, returns pc.
  - 2 SCRATCH: R/W, per-byte-lane writes.
  - 3 ID: read-only, ID_VALUE.
  - Writes to read-only CSRs are acknowledged with no side effect.
- FSM states: IDLE, MEM_WAIT, ACK, RELEASE.
- IDLE, request seen at cycle T (read|write=1); request fields captured at T:
  - Write wins if read and write are both 1; the read is dropped.
  - Memory write: mem_we=1, mem_be, mem_wdata and mem_addr driven at T+1; avalon_acknowledge=1 at T+1; go to RELEASE.
  - Memory write with byte_enable=0000: no mem_we, still acknowledged at T+1.
  - Memory read: mem_re=1 at T+1; go to MEM_WAIT; count MEM_LAT cycles; mem_rdata registered at T+1+MEM_LAT; avalon_acknowledge=1 with data at T+2+MEM_LAT; go to RELEASE.
  - CSR read/write: executed at T+1, acknowledge at T+1 (read data registered); go to RELEASE.
  - cpu_step pulses at T+1 for exactly 1 cycle.
- RELEASE: wait until read=0 and write=0, then IDLE. A held request is never executed twice; the earliest back-to-back acceptance is the cycle after the deassert is seen.
- avalon_acknowledge is exactly one cycle per request. avalon_read_data is 0 when acknowledge=0 and for write acknowledges.
- Request field changes between acceptance and acknowledge are ignored (captured copy used).
- Non-HPS builds do not instantiate this block.

Decomposition:
- Package hps_avalon_pkg holds:
  - state encoding (IDLE, MEM_WAIT, ACK, RELEASE);
  - region select bit index 23;
  - CSR offsets CTRL=0, STATUS=1, SCRATCH=2, ID=3;
  - CTRL bit positions RUN=0, STEP=1.
- Sub-module hps_csr_block: CSR storage, byte-lane write masking, step pulse and read mux. Single-cycle read/write interface driven by the FSM.

Test Plan:
- Memory write addr 0x000010, be=1111, data 0xCAFEBABE, held until ack -> mem_we for 1 cycle with mem_addr=4, mem_wdata=0xCAFEBABE; ack at T+1; no second mem_we while write remains high.
- Memory read addr 0x000010, MEM_LAT=2, model returns 0x12345678 -> mem_re at T+1, ack at T+4 with read_data=0x12345678; exactly one ack.
- CSR: write SCRATCH (0x800008) be=0101 data 0xAABBCCDD after scratch=0 -> read returns 0x00BB00DD. Read ID (0x80000C) -> 0x4D495053. Read STATUS with pc=0x00400020 -> 0x00400020.
- CTRL write 0x00000002 (0x800000) -> cpu_step high exactly 1 cycle, cpu_run=0. Write 0x1 -> cpu_run=1. Read CTRL -> 0x00000001.
- read=1 and write=1 together at SCRATCH with data 0x55 -> write performed, ack once, read_data=0. Write to ID -> acked, ID unchanged.
- resetn low during MEM_WAIT -> no ack after release of reset, outputs at reset values, cpu_run=RUN_AT_RESET; next request completes normally.

Source files
------------

// File: rtl/hps_avalon_responder_pkg.sv
// Shared encodings for the HPS Avalon responder: FSM states, address decode, CSR map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hps_avalon_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    ACK      = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Byte-address bit that selects the CSR half of the space.
  localparam int REGION_BIT = 23;

  // CSR word offsets (byte address bits [3:2]).
  localparam logic [1:0] CSR_CTRL    = 2'd0;
  localparam logic [1:0] CSR_STATUS  = 2'd1;
  localparam logic [1:0] CSR_SCRATCH = 2'd2;
  localparam logic [1:0] CSR_ID      = 2'd3;

  // CTRL register bit positions.
  localparam int CTRL_RUN  = 0;
  localparam int CTRL_STEP = 1;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hps_avalon_responder_if.sv
// HPS Avalon request/acknowledge bus between the HPS initiator and the fabric responder.
// Latency: n/a (wiring only).
// Backpressure: requests are held by the initiator until a one-cycle acknowledge.
interface hps_avalon_responder_if;

  logic [23:0] avalon_address;
  logic [3:0]  avalon_byte_enable;
  logic        avalon_read;
  logic        avalon_write;
  logic [31:0] avalon_write_data;
  logic        avalon_acknowledge;
  logic [31:0] avalon_read_data;

  modport master (
    output avalon_address, avalon_byte_enable, avalon_read, avalon_write, avalon_write_data,
    input  avalon_acknowledge, avalon_read_data
  );

  modport slave (
    input  avalon_address, avalon_byte_enable, avalon_read, avalon_write, avalon_write_data,
    output avalon_acknowledge, avalon_read_data
  );

endinterface

// File: rtl/hps_avalon_responder_csr.sv
// CPU control CSRs: run/step control, PC readback, scratch word and ID word.
// Latency: writes take effect on the next edge; read data is combinational from csr_re.
// Backpressure: none, every access completes in the cycle it is presented.
module hps_csr_block
  import hps_avalon_pkg::*;
#(
  parameter bit          RUN_AT_RESET = 1'b1,
  parameter logic [31:0] ID_VALUE     = 32'h4D495053
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        csr_re,
  input  logic        csr_we,
  input  logic [1:0]  csr_offset,
  input  logic [3:0]  csr_be,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] pc,
  output logic [31:0] csr_rdata,
  output logic        cpu_run,
  output logic        cpu_step
);

  logic        run_q;
  logic        step_q;
  logic [31:0] scratch_q;

  // Register writes; step is a self-clearing pulse, CTRL only honours lane 0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      run_q     <= RUN_AT_RESET;
      step_q    <= 1'b0;
      scratch_q <= '0;
    end else begin
      step_q <= 1'b0;
      if (csr_we) begin
        case (csr_offset)
          CSR_CTRL: begin
            if (csr_be[0]) begin
              run_q  <= csr_wdata[CTRL_RUN];
              step_q <= csr_wdata[CTRL_STEP];
            end
          end
          CSR_SCRATCH: scratch_q <= lane_merge(scratch_q, csr_wdata, csr_be);
          default: ;  // STATUS and ID ignore writes
        endcase
      end
    end
  end

  // Read mux; the step bit always reads back as zero.
  always_comb begin
    csr_rdata = '0;
    if (csr_re) begin
      case (csr_offset)
        CSR_CTRL:    csr_rdata[CTRL_RUN] = run_q;
        CSR_STATUS:  csr_rdata = pc;
        CSR_SCRATCH: csr_rdata = scratch_q;
        default:     csr_rdata = ID_VALUE;
      endcase
    end
  end

  assign cpu_run  = run_q;
  assign cpu_step = step_q;

endmodule

// File: rtl/hps_avalon_responder.sv
// HPS Avalon responder: lower half of the space to a fixed-latency memory port, upper half to CSRs.
// Latency: writes and CSR reads ack 1 cycle after acceptance, memory reads ack MEM_LAT+2 cycles after.
// Backpressure: a request is held by the HPS until acked; it is not re-accepted until read/write drop.
module hps_avalon_responder
  import hps_avalon_pkg::*;
#(
  parameter int          MEM_AW       = 14,
  parameter int          MEM_LAT      = 2,
  parameter bit          RUN_AT_RESET = 1'b1,
  parameter logic [31:0] ID_VALUE     = 32'h4D495053
) (
  input  logic                  clock,
  input  logic                  resetn,
  hps_avalon_responder_if.slave avalon,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic [31:0]           pc,
  output logic                  cpu_run,
  output logic                  cpu_step
);

  state_t              state, state_nxt;
  logic [2:0]          lat_cnt, lat_cnt_nxt;
  logic                ack_q, ack_nxt;
  logic [31:0]         rdata_q, rdata_nxt;
  logic                mem_re_nxt, mem_we_nxt;
  logic [MEM_AW-1:0]   mem_addr_nxt;
  logic [3:0]          mem_be_nxt;
  logic [31:0]         mem_wdata_nxt;
  logic                csr_re, csr_we;
  logic [31:0]         csr_rdata;
  logic                req, is_csr;

  // Only some address bits are decoded; the rest alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^avalon.avalon_address;

  assign req    = avalon.avalon_read | avalon.avalon_write;
  assign is_csr = avalon.avalon_address[REGION_BIT];

  hps_csr_block #(
    .RUN_AT_RESET (RUN_AT_RESET),
    .ID_VALUE     (ID_VALUE)
  ) u_csr (
    .clock      (clock),
    .resetn     (resetn),
    .csr_re     (csr_re),
    .csr_we     (csr_we),
    .csr_offset (avalon.avalon_address[3:2]),
    .csr_be     (avalon.avalon_byte_enable),
    .csr_wdata  (avalon.avalon_write_data),
    .pc         (pc),
    .csr_rdata  (csr_rdata),
    .cpu_run    (cpu_run),
    .cpu_step   (cpu_step)
  );

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      lat_cnt   <= lat_cnt_nxt;
      ack_q     <= ack_nxt;
      rdata_q   <= rdata_nxt;
      mem_re    <= mem_re_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_be    <= mem_be_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

  // Next-state and output decode; a write beats a simultaneous read.
  always_comb begin
    state_nxt     = state;
    lat_cnt_nxt   = lat_cnt;
    ack_nxt       = 1'b0;
    rdata_nxt     = '0;
    mem_re_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_be_nxt    = mem_be;
    mem_wdata_nxt = mem_wdata;
    csr_re        = 1'b0;
    csr_we        = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (is_csr) begin
            csr_we    = avalon.avalon_write;
            csr_re    = ~avalon.avalon_write;
            rdata_nxt = csr_rdata;
            ack_nxt   = 1'b1;
            state_nxt = RELEASE;
          end else begin
            mem_addr_nxt = avalon.avalon_address[MEM_AW+1:2];
            if (avalon.avalon_write) begin
              mem_we_nxt    = |avalon.avalon_byte_enable;
              mem_be_nxt    = avalon.avalon_byte_enable;
              mem_wdata_nxt = avalon.avalon_write_data;
              ack_nxt       = 1'b1;
              state_nxt     = RELEASE;
            end else begin
              mem_re_nxt  = 1'b1;
              lat_cnt_nxt = 3'(MEM_LAT - 1);
              state_nxt   = MEM_WAIT;
            end
          end
        end
      end
      MEM_WAIT: begin
        if (lat_cnt == '0) state_nxt = ACK;
        else               lat_cnt_nxt = lat_cnt - 3'd1;
      end
      ACK: begin
        ack_nxt   = 1'b1;
        rdata_nxt = mem_rdata;
        state_nxt = RELEASE;
      end
      default: begin
        if (!req) state_nxt = IDLE;
      end
    endcase
  end

  assign avalon.avalon_acknowledge = ack_q;
  assign avalon.avalon_read_data   = rdata_q;

endmodule

// File: tb/tb_hps_avalon_responder.sv
// Self-checking bench for hps_avalon_responder with a latency-accurate memory model.
// Latency: n/a.
// Backpressure: requests are held until acknowledged, then released after a random hold.
module tb_hps_avalon_responder;

  localparam int          MEM_AW  = 14;
  localparam int          MEM_LAT = 2;
  localparam logic [31:0] ID      = 32'h4D495053;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  hps_avalon_responder_if bus();

  logic [MEM_AW-1:0] mem_addr;
  logic              mem_re, mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata, mem_rdata, pc;
  logic              cpu_run, cpu_step;

  hps_avalon_responder #(
    .MEM_AW(MEM_AW), .MEM_LAT(MEM_LAT), .RUN_AT_RESET(1'b1), .ID_VALUE(ID)
  ) dut (
    .clock(clock), .resetn(resetn), .avalon(bus),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pc(pc),
    .cpu_run(cpu_run), .cpu_step(cpu_step)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] init_val(input int i);
    logic [15:0] w;
    w = 16'(i);
    return (i == 4) ? 32'h12345678 : {w, ~w};
  endfunction

  // Memory device: applies strobes and returns data MEM_LAT cycles after mem_re.
  logic [31:0]       dev_mem [0:16383];
  logic              pipe_vld [0:7];
  logic [MEM_AW-1:0] pipe_addr [0:7];
  logic              init_req = 1'b1;

  always @(posedge clock) begin
    if (init_req) begin
      for (int i = 0; i < 16384; i++) dev_mem[i] <= init_val(i);
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) dev_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin pipe_vld[i] <= 1'b0; pipe_addr[i] <= '0; end
    end else begin
      for (int i = 7; i > 0; i--) begin pipe_vld[i] <= pipe_vld[i-1]; pipe_addr[i] <= pipe_addr[i-1]; end
      pipe_vld[0]  <= mem_re;
      pipe_addr[0] <= mem_addr;
    end
  end
  assign mem_rdata = pipe_vld[MEM_LAT-1] ? dev_mem[pipe_addr[MEM_LAT-1]] : 32'hBAD0BAD0;

  // Observation counters, sampled mid-cycle.
  int          cyc = 0;
  int          ack_cnt = 0, we_cnt = 0, re_cnt = 0, step_hi = 0, bad_rd = 0;
  int          re_cyc = 0, we_cyc = 0;
  logic [13:0] we_addr = '0, re_addr = '0;
  logic [31:0] we_data = '0;
  logic [3:0]  we_be = '0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.avalon_acknowledge) ack_cnt <= ack_cnt + 1;
    if (!bus.avalon_acknowledge && bus.avalon_read_data !== 32'h0) bad_rd <= bad_rd + 1;
    if (mem_re) begin re_cnt <= re_cnt + 1; re_cyc <= cyc; re_addr <= mem_addr; end
    if (mem_we) begin
      we_cnt <= we_cnt + 1; we_cyc <= cyc; we_addr <= mem_addr; we_data <= mem_wdata; we_be <= mem_be;
    end
    if (cpu_step) step_hi <= step_hi + 1;
  end

  // Reference model state, defined from the register map rather than the RTL.
  logic [31:0] ref_mem [0:16383];
  logic        ref_run;
  logic [31:0] ref_scratch;

  task automatic model(input bit wr, input logic [23:0] addr, input logic [3:0] be,
                       input logic [31:0] data, output logic [31:0] er, output int el);
    int w;
    w  = int'(addr[15:2]);
    er = 32'h0;
    el = 1;
    if (!addr[23]) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
      end else begin
        er = ref_mem[w];
        el = 2 + MEM_LAT;
      end
    end else begin
      case (addr[3:2])
        2'd0: if (wr) begin if (be[0]) ref_run = data[0]; end else er = {31'h0, ref_run};
        2'd1: if (!wr) er = pc;
        2'd2: if (wr) begin
                for (int b = 0; b < 4; b++) if (be[b]) ref_scratch[8*b +: 8] = data[8*b +: 8];
              end else er = ref_scratch;
        default: if (!wr) er = ID;
      endcase
    end
  endtask

  // One request held until ack (fields scrambled after acceptance), then held 'hold' more cycles.
  task automatic do_req(input bit wr, input bit rd, input logic [23:0] addr, input logic [3:0] be,
                        input logic [31:0] data, input int hold,
                        output logic [31:0] rdata, output int lat, output int s_cyc);
    int n;
    @(negedge clock);
    bus.avalon_write = wr; bus.avalon_read = rd; bus.avalon_address = addr;
    bus.avalon_byte_enable = be; bus.avalon_write_data = data;
    s_cyc = cyc; lat = -1; rdata = 32'h0; n = 0;
    while (lat < 0 && n < 40) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        bus.avalon_address = 24'($urandom); bus.avalon_write_data = $urandom;
        bus.avalon_byte_enable = 4'($urandom);
      end
      if (bus.avalon_acknowledge) begin lat = n; rdata = bus.avalon_read_data; end
    end
    repeat (hold) @(negedge clock);
    bus.avalon_read = 1'b0; bus.avalon_write = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset;
    bus.avalon_read = 0; bus.avalon_write = 0; bus.avalon_address = 0;
    bus.avalon_byte_enable = 0; bus.avalon_write_data = 0; pc = 0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = init_val(i);
    ref_run = 1'b1; ref_scratch = 32'h0;
    repeat (2) @(negedge clock);
    n_cmp++; if (bus.avalon_acknowledge !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b expected 0", bus.avalon_acknowledge); end
    n_cmp++; if (bus.avalon_read_data !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h expected 0", bus.avalon_read_data); end
    n_cmp++; if (mem_re !== 1'b0) begin n_err++; $display("FAIL rst_mem_re: got %b expected 0", mem_re); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    n_cmp++; if (mem_addr !== 14'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    n_cmp++; if (mem_be !== 4'h0) begin n_err++; $display("FAIL rst_mem_be: got %h expected 0", mem_be); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
    n_cmp++; if (cpu_run !== 1'b1) begin n_err++; $display("FAIL rst_cpu_run: got %b expected 1", cpu_run); end
    n_cmp++; if (cpu_step !== 1'b0) begin n_err++; $display("FAIL rst_cpu_step: got %b expected 0", cpu_step); end
    init_req = 1'b0;
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_mem_read;
    logic [31:0] r, er; int l, el, s, a0, r0;
    a0 = ack_cnt; r0 = re_cnt;
    model(1'b0, 24'h000010, 4'hF, 32'h0, er, el);
    do_req(1'b0, 1'b1, 24'h000010, 4'hF, 32'h0, 2, r, l, s);
    n_cmp++; if (r !== 32'h12345678 || r !== er) begin n_err++; $display("FAIL mrd_data: got %h expected %h", r, er); end
    n_cmp++; if (l !== 4) begin n_err++; $display("FAIL mrd_lat: got %0d expected 4", l); end
    n_cmp++; if (re_cnt - r0 !== 1) begin n_err++; $display("FAIL mrd_re_cnt: got %0d expected 1", re_cnt - r0); end
    n_cmp++; if (re_cyc - s !== 1) begin n_err++; $display("FAIL mrd_re_time: got %0d expected 1", re_cyc - s); end
    n_cmp++; if (re_addr !== 14'd4) begin n_err++; $display("FAIL mrd_addr: got %h expected 4", re_addr); end
    n_cmp++; if (ack_cnt - a0 !== 1) begin n_err++; $display("FAIL mrd_acks: got %0d expected 1", ack_cnt - a0); end
  endtask

  task automatic test_mem_write;
    logic [31:0] r, er; int l, el, s, a0, w0;
    a0 = ack_cnt; w0 = we_cnt;
    model(1'b1, 24'h000010, 4'hF, 32'hCAFEBABE, er, el);
    do_req(1'b1, 1'b0, 24'h000010, 4'hF, 32'hCAFEBABE, 4, r, l, s);
    n_cmp++; if (l !== 1) begin n_err++; $display("FAIL mwr_lat: got %0d expected 1", l); end
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL mwr_rdata: got %h expected 0", r); end
    n_cmp++; if (we_cnt - w0 !== 1) begin n_err++; $display("FAIL mwr_we_cnt: got %0d expected 1", we_cnt - w0); end
    n_cmp++; if (we_cyc - s !== 1) begin n_err++; $display("FAIL mwr_we_time: got %0d expected 1", we_cyc - s); end
    n_cmp++; if (we_addr !== 14'd4) begin n_err++; $display("FAIL mwr_addr: got %h expected 4", we_addr); end
    n_cmp++; if (we_data !== 32'hCAFEBABE) begin n_err++; $display("FAIL mwr_data: got %h expected cafebabe", we_data); end
    n_cmp++; if (we_be !== 4'hF) begin n_err++; $display("FAIL mwr_be: got %h expected f", we_be); end
    n_cmp++; if (ack_cnt - a0 !== 1) begin n_err++; $display("FAIL mwr_acks: got %0d expected 1", ack_cnt - a0); end
    // Zero byte enables: acknowledged, but no strobe reaches memory.
    w0 = we_cnt;
    model(1'b1, 24'h000014, 4'h0, 32'h11111111, er, el);
    do_req(1'b1, 1'b0, 24'h000014, 4'h0, 32'h11111111, 0, r, l, s);
    n_cmp++; if (l !== 1) begin n_err++; $display("FAIL mwr_be0_lat: got %0d expected 1", l); end
    n_cmp++; if (we_cnt - w0 !== 0) begin n_err++; $display("FAIL mwr_be0_we: got %0d expected 0", we_cnt - w0); end
    model(1'b0, 24'h000010, 4'hF, 32'h0, er, el);
    do_req(1'b0, 1'b1, 24'h000010, 4'hF, 32'h0, 0, r, l, s);
    n_cmp++; if (r !== er) begin n_err++; $display("FAIL mwr_readback: got %h expected %h", r, er); end
  endtask

  task automatic test_csr;
    logic [31:0] r, er; int l, el, s;
    model(1'b1, 24'h800008, 4'b0101, 32'hAABBCCDD, er, el);
    do_req(1'b1, 1'b0, 24'h800008, 4'b0101, 32'hAABBCCDD, 1, r, l, s);
    n_cmp++; if (l !== 1) begin n_err++; $display("FAIL csr_wr_lat: got %0d expected 1", l); end
    model(1'b0, 24'h800008, 4'hF, 32'h0, er, el);
    do_req(1'b0, 1'b1, 24'h800008, 4'hF, 32'h0, 1, r, l, s);
    n_cmp++; if (r !== 32'h00BB00DD) begin n_err++; $display("FAIL csr_scratch: got %h expected 00bb00dd", r); end
    do_req(1'b0, 1'b1, 24'h80000C, 4'hF, 32'h0, 0, r, l, s);
    n_cmp++; if (r !== ID) begin n_err++; $display("FAIL csr_id: got %h expected %h", r, ID); end
    pc = 32'h00400020;
    do_req(1'b0, 1'b1, 24'h800004, 4'hF, 32'h0, 2, r, l, s);
    n_cmp++; if (r !== 32'h00400020) begin n_err++; $display("FAIL csr_status: got %h expected 00400020", r); end
    n_cmp++; if (l !== 1) begin n_err++; $display("FAIL csr_rd_lat: got %0d expected 1", l); end
  endtask

  task automatic test_ctrl;
    logic [31:0] r, er; int l, el, s, st0;
    st0 = step_hi;
    model(1'b1, 24'h800000, 4'hF, 32'h2, er, el);
    do_req(1'b1, 1'b0, 24'h800000, 4'hF, 32'h2, 3, r, l, s);
    n_cmp++; if (step_hi - st0 !== 1) begin n_err++; $display("FAIL ctrl_step_cycles: got %0d expected 1", step_hi - st0); end
    n_cmp++; if (cpu_run !== ref_run) begin n_err++; $display("FAIL ctrl_run_clear: got %b expected %b", cpu_run, ref_run); end
    model(1'b1, 24'h800000, 4'hF, 32'h1, er, el);
    do_req(1'b1, 1'b0, 24'h800000, 4'hF, 32'h1, 0, r, l, s);
    n_cmp++; if (cpu_run !== 1'b1) begin n_err++; $display("FAIL ctrl_run_set: got %b expected 1", cpu_run); end
    model(1'b0, 24'h800000, 4'hF, 32'h0, er, el);
    do_req(1'b0, 1'b1, 24'h800000, 4'hF, 32'h0, 0, r, l, s);
    n_cmp++; if (r !== 32'h1 || r !== er) begin n_err++; $display("FAIL ctrl_read: got %h expected %h", r, er); end
    // Lane 0 disabled: neither run nor step may change.
    st0 = step_hi;
    model(1'b1, 24'h800000, 4'hE, 32'h2, er, el);
    do_req(1'b1, 1'b0, 24'h800000, 4'hE, 32'h2, 0, r, l, s);
    n_cmp++; if (step_hi - st0 !== 0) begin n_err++; $display("FAIL ctrl_be0_step: got %0d expected 0", step_hi - st0); end
    n_cmp++; if (cpu_run !== ref_run) begin n_err++; $display("FAIL ctrl_be0_run: got %b expected %b", cpu_run, ref_run); end
  endtask

  task automatic test_rw_conflict;
    logic [31:0] r, er; int l, el, s, a0;
    a0 = ack_cnt;
    model(1'b1, 24'h800008, 4'hF, 32'h55, er, el);
    do_req(1'b1, 1'b1, 24'h800008, 4'hF, 32'h55, 3, r, l, s);
    n_cmp++; if (l !== 1) begin n_err++; $display("FAIL rw_lat: got %0d expected 1", l); end
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL rw_rdata: got %h expected 0", r); end
    n_cmp++; if (ack_cnt - a0 !== 1) begin n_err++; $display("FAIL rw_acks: got %0d expected 1", ack_cnt - a0); end
    do_req(1'b0, 1'b1, 24'h800008, 4'hF, 32'h0, 0, r, l, s);
    n_cmp++; if (r !== 32'h55) begin n_err++; $display("FAIL rw_scratch: got %h expected 00000055", r); end
    model(1'b1, 24'h80000C, 4'hF, 32'h0, er, el);
    do_req(1'b1, 1'b0, 24'h80000C, 4'hF, 32'h0, 0, r, l, s);
    n_cmp++; if (l !== 1) begin n_err++; $display("FAIL ro_wr_lat: got %0d expected 1", l); end
    do_req(1'b0, 1'b1, 24'h80000C, 4'hF, 32'h0, 0, r, l, s);
    n_cmp++; if (r !== ID) begin n_err++; $display("FAIL ro_id_kept: got %h expected %h", r, ID); end
  endtask

  task automatic test_random;
    logic [31:0] r, er, data; logic [23:0] addr; logic [3:0] be; logic [13:0] word;
    bit wr, rd, csr; int l, el, s, a0, w0, ew;
    for (int i = 0; i < 40; i++) begin
      pc   = $urandom;
      wr   = 1'($urandom_range(0, 1));
      rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      csr  = ($urandom_range(0, 2) == 0);
      be   = 4'($urandom);
      data = $urandom;
      word = ($urandom_range(0, 1) ? 14'h3FF0 : 14'h0000) | 14'($urandom_range(0, 15));
      if (csr) addr = {1'b1, 19'($urandom), 2'($urandom), 2'($urandom)};
      else     addr = {1'b0, 7'($urandom), word, 2'($urandom)};
      ew = (wr && !csr && be != 4'h0) ? 1 : 0;
      a0 = ack_cnt; w0 = we_cnt;
      model(wr, addr, be, data, er, el);
      do_req(wr, rd, addr, be, data, $urandom_range(0, 3), r, l, s);
      n_cmp++; if (r !== er) begin n_err++; $display("FAIL rand%0d_rdata: got %h expected %h (addr %h wr %b)", i, r, er, addr, wr); end
      n_cmp++; if (l !== el) begin n_err++; $display("FAIL rand%0d_lat: got %0d expected %0d", i, l, el); end
      n_cmp++; if (ack_cnt - a0 !== 1 || we_cnt - w0 !== ew) begin
        n_err++; $display("FAIL rand%0d_pulses: got acks %0d we %0d expected acks 1 we %0d", i, ack_cnt - a0, we_cnt - w0, ew);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r, er; int l, el, s, a0;
    model(1'b1, 24'h800000, 4'h1, 32'h0, er, el);
    do_req(1'b1, 1'b0, 24'h800000, 4'h1, 32'h0, 0, r, l, s);
    n_cmp++; if (cpu_run !== 1'b0) begin n_err++; $display("FAIL mid_run_off: got %b expected 0", cpu_run); end
    @(negedge clock);
    bus.avalon_address = 24'h000010; bus.avalon_byte_enable = 4'hF; bus.avalon_read = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b0; bus.avalon_read = 1'b0;
    ref_run = 1'b1; ref_scratch = 32'h0;
    a0 = ack_cnt;
    @(negedge clock);
    n_cmp++; if (bus.avalon_acknowledge !== 1'b0) begin n_err++; $display("FAIL mid_ack: got %b expected 0", bus.avalon_acknowledge); end
    n_cmp++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL mid_strobes: got re %b we %b expected 0 0", mem_re, mem_we); end
    n_cmp++; if (cpu_run !== 1'b1) begin n_err++; $display("FAIL mid_cpu_run: got %b expected 1", cpu_run); end
    n_cmp++; if (mem_addr !== 14'h0) begin n_err++; $display("FAIL mid_mem_addr: got %h expected 0", mem_addr); end
    @(negedge clock);
    resetn = 1'b1;
    repeat (8) @(negedge clock);
    n_cmp++; if (ack_cnt - a0 !== 0) begin n_err++; $display("FAIL mid_no_ack: got %0d expected 0", ack_cnt - a0); end
    model(1'b0, 24'h800008, 4'hF, 32'h0, er, el);
    do_req(1'b0, 1'b1, 24'h800008, 4'hF, 32'h0, 0, r, l, s);
    n_cmp++; if (r !== er) begin n_err++; $display("FAIL mid_scratch: got %h expected %h", r, er); end
    model(1'b0, 24'h000010, 4'hF, 32'h0, er, el);
    do_req(1'b0, 1'b1, 24'h000010, 4'hF, 32'h0, 1, r, l, s);
    n_cmp++; if (r !== er) begin n_err++; $display("FAIL mid_mem_read: got %h expected %h", r, er); end
    n_cmp++; if (l !== 2 + MEM_LAT) begin n_err++; $display("FAIL mid_mem_lat: got %0d expected %0d", l, 2 + MEM_LAT); end
  endtask

  task automatic test_idle_data;
    n_cmp++; if (bad_rd !== 0) begin n_err++; $display("FAIL idle_rdata: got %0d nonzero idle cycles expected 0", bad_rd); end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_csr();
    test_ctrl();
    test_rw_conflict();
    test_random();
    test_reset_mid();
    test_idle_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
